// File: rtl/dsp38_mac_sequencer.sv
// Tap sequencer feeding a DSP38 MAC: one NUM_TAPS-long dot product per accepted sample.
// Optional macro SEQ_COEF_WRITE_EN enables runtime coefficient writes; otherwise coefficients are fixed at COEFF_INIT.
module dsp38_mac_sequencer #(
  parameter int                      NUM_TAPS    = 4,
  parameter logic [20*NUM_TAPS-1:0]  COEFF_INIT  = '0,
  parameter int                      DSP_LATENCY = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        S_VALID,
  output logic        S_READY,
  input  logic [17:0] S_DATA,
  input  logic        COEF_WE,
  input  logic [3:0]  COEF_ADDR,
  input  logic [19:0] COEF_DATA,
  output logic        COEF_ERR,
  output logic [19:0] A,
  output logic [17:0] B,
  output logic        LOAD_ACC,
  output logic [2:0]  FEEDBACK,
  output logic        OUT_VALID
);

  localparam int KW = $clog2(NUM_TAPS);

  typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [1:0]      drain_q, drain_d;
  logic            out_valid_q, out_valid_d;
  logic [17:0]     hist_q [NUM_TAPS];
  logic [19:0]     coef_init [NUM_TAPS];
  logic [19:0]     tap_coef;
  logic            accept;
  logic            last_tap;
  logic            in_mac;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_coef_init
      assign coef_init[gi] = COEFF_INIT[20*gi +: 20];
    end
  endgenerate

  assign accept   = S_VALID && (state_q == IDLE);
  assign last_tap = (k_q == KW'(NUM_TAPS - 1));
  assign in_mac   = (state_q == MAC);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    drain_d     = drain_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MAC;
          k_d     = '0;
        end
      end
      MAC: begin
        if (last_tap) begin
          k_d = '0;
          if (DSP_LATENCY == 0) begin
            state_d     = IDLE;
            out_valid_d = 1'b1;
          end else begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      DRAIN: begin
        // OUT_VALID is registered, so it lands together with the return to IDLE.
        if (drain_q == 2'(DSP_LATENCY - 1)) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      k_q         <= '0;
      drain_q     <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) hist_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      drain_q     <= drain_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        hist_q[0] <= S_DATA;
        for (int i = 1; i < NUM_TAPS; i++) hist_q[i] <= hist_q[i-1];
      end
    end
  end

`ifdef SEQ_COEF_WRITE_EN
  logic [19:0] coef_q [NUM_TAPS];
  logic        coef_err_q;
  logic        addr_ok;
  logic        coef_wr_ok;

  assign addr_ok    = int'(COEF_ADDR) < NUM_TAPS;
  assign coef_wr_ok = COEF_WE && (state_q == IDLE) && addr_ok;

  // A write landing on the acceptance edge is visible to tap 0 in the next cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NUM_TAPS; i++) coef_q[i] <= coef_init[i];
      coef_err_q <= 1'b0;
    end else begin
      if (coef_wr_ok) coef_q[COEF_ADDR[KW-1:0]] <= COEF_DATA;
      coef_err_q <= COEF_WE && !coef_wr_ok;
    end
  end

  assign tap_coef = coef_q[k_q];
  assign COEF_ERR = coef_err_q;
`else
  logic unused_coef_port;
  assign unused_coef_port = ^{COEF_WE, COEF_ADDR, COEF_DATA};
  assign tap_coef = coef_init[k_q];
  assign COEF_ERR = 1'b0;
`endif

  assign S_READY   = (state_q == IDLE);
  assign A         = in_mac ? tap_coef : '0;
  assign B         = in_mac ? hist_q[k_q] : '0;
  assign LOAD_ACC  = in_mac;
  assign FEEDBACK  = {2'b00, in_mac && (k_q == '0)};
  assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_dsp38_mac_sequencer.sv
// Directed bench for dsp38_mac_sequencer: 4 taps, DSP latency 1, coefficients {4,3,2,1}.
module tb_dsp38_mac_sequencer;

  localparam int NT = 4;
  localparam int DL = 1;
  localparam logic [20*NT-1:0] CINIT = {20'd4, 20'd3, 20'd2, 20'd1};
`ifdef SEQ_COEF_WRITE_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [17:0] s_data;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [19:0] coef_data;
  logic        coef_err;
  logic [19:0] a;
  logic [17:0] b;
  logic        load_acc;
  logic [2:0]  feedback;
  logic        out_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dsp38_mac_sequencer #(
    .NUM_TAPS(NT), .COEFF_INIT(CINIT), .DSP_LATENCY(DL)
  ) dut (
    .CLK(clk), .RESET(rst), .S_VALID(s_valid), .S_READY(s_ready), .S_DATA(s_data),
    .COEF_WE(coef_we), .COEF_ADDR(coef_addr), .COEF_DATA(coef_data), .COEF_ERR(coef_err),
    .A(a), .B(b), .LOAD_ACC(load_acc), .FEEDBACK(feedback), .OUT_VALID(out_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tap(input string tag, input int ea, input int eb, input int efb);
    chk({tag, ".A"}, 32'(a), 32'(ea));
    chk({tag, ".B"}, 32'(b), 32'(eb));
    chk({tag, ".FB"}, 32'(feedback), 32'(efb));
    chk({tag, ".LOAD"}, 32'(load_acc), 32'd1);
    chk({tag, ".RDY"}, 32'(s_ready), 32'd0);
    chk({tag, ".OV"}, 32'(out_valid), 32'd0);
  endtask

  task automatic chk_quiet(input string tag, input int eov);
    chk({tag, ".A"}, 32'(a), 32'd0);
    chk({tag, ".B"}, 32'(b), 32'd0);
    chk({tag, ".FB"}, 32'(feedback), 32'd0);
    chk({tag, ".LOAD"}, 32'(load_acc), 32'd0);
    chk({tag, ".OV"}, 32'(out_valid), 32'(eov));
  endtask

  int acc_cnt;
  int out_cnt;
  int acc_at [8];

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;

    // Reset held for two edges
    step(); step();
    chk("rst.RDY", 32'(s_ready), 32'd1);
    chk("rst.ERR", 32'(coef_err), 32'd0);
    chk_quiet("rst", 0);
    rst = 1'b0;
    step();
    chk_quiet("idle", 0);

    // First sample: 5
    s_valid = 1'b1; s_data = 18'd5;
    step(); s_valid = 1'b0;
    chk_tap("s1t0", 1, 5, 1); step();
    chk_tap("s1t1", 2, 0, 0); step();
    chk_tap("s1t2", 3, 0, 0); step();
    chk_tap("s1t3", 4, 0, 0); step();
    chk_quiet("s1drain", 0);
    chk("s1drain.RDY", 32'(s_ready), 32'd0);
    step();
    chk_quiet("s1done", 1);
    chk("s1done.RDY", 32'(s_ready), 32'd1);

    // Second sample: 6
    s_valid = 1'b1; s_data = 18'd6;
    step(); s_valid = 1'b0;
    chk_tap("s2t0", 1, 6, 1); step();
    chk_tap("s2t1", 2, 5, 0); step();
    chk_tap("s2t2", 3, 0, 0); step();
    chk_tap("s2t3", 4, 0, 0); step();
    chk_quiet("s2drain", 0);
    step();
    chk_quiet("s2done", 1);
    step();
    chk_quiet("s2after", 0);

    // Continuous S_VALID: acceptances at points 0,6,12,18; outputs at 6,12,18,24
    acc_cnt = 0; out_cnt = 0;
    s_data = 18'd9;
    for (int i = 0; i <= 24; i++) begin
      s_valid = (i <= 18);
      if (out_valid) out_cnt++;
      if (s_valid && s_ready && acc_cnt < 8) begin
        acc_at[acc_cnt] = i;
        acc_cnt++;
      end
      step();
    end
    s_valid = 1'b0;
    chk("cont.accepts", 32'(acc_cnt), 32'd4);
    chk("cont.outs", 32'(out_cnt), 32'd4);
    for (int i = 1; i < 4; i++) chk("cont.gap", 32'(acc_at[i] - acc_at[i-1]), 32'd6);
    chk_quiet("cont.end", 0);

    // Coefficient write in IDLE: addr 2 <= 7
    coef_we = 1'b1; coef_addr = 4'd2; coef_data = 20'd7;
    step(); coef_we = 1'b0;
    chk("wr.idle.ERR", 32'(coef_err), 32'd0);

    // Sample 3 (hist 3,9,9,9); write during MAC must be dropped
    s_valid = 1'b1; s_data = 18'd3;
    step(); s_valid = 1'b0;
    chk_tap("s3t0", 1, 3, 1);
    coef_we = 1'b1; coef_addr = 4'd1; coef_data = 20'd99;
    step(); coef_we = 1'b0;
    chk_tap("s3t1", 2, 9, 0);
    chk("wr.mac.ERR", 32'(coef_err), 32'(WR_EN));
    step();
    chk_tap("s3t2", WR_EN ? 7 : 3, 9, 0);
    chk("wr.mac.ERRpulse", 32'(coef_err), 32'd0);
    step();
    chk_tap("s3t3", 4, 9, 0); step();
    step();
    chk_quiet("s3done", 1);

    // Out-of-range address
    coef_we = 1'b1; coef_addr = 4'd9; coef_data = 20'd55;
    step(); coef_we = 1'b0;
    chk("wr.addr9.ERR", 32'(coef_err), 32'(WR_EN));
    step();
    chk("wr.addr9.ERRpulse", 32'(coef_err), 32'd0);

    // Simultaneous sample 1 and write tap0 <= 11 (hist 1,3,9,9)
    s_valid = 1'b1; s_data = 18'd1;
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 20'd11;
    step(); s_valid = 1'b0; coef_we = 1'b0;
    chk_tap("s4t0", WR_EN ? 11 : 1, 1, 1);
    chk("s4.ERR", 32'(coef_err), 32'd0);
    step();
    chk_tap("s4t1", 2, 3, 0); step();
    chk_tap("s4t2", WR_EN ? 7 : 3, 9, 0); step();
    chk_tap("s4t3", 4, 9, 0); step();
    step();
    chk_quiet("s4done", 1);

    // Reset at tap 2 aborts the sample
    s_valid = 1'b1; s_data = 18'd2;
    step(); s_valid = 1'b0;
    chk_tap("s5t0", WR_EN ? 11 : 1, 2, 1); step();
    chk_tap("s5t1", 2, 1, 0); step();
    chk_tap("s5t2", WR_EN ? 7 : 3, 3, 0);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("abort.RDY", 32'(s_ready), 32'd1);
    chk_quiet("abort", 0);
    out_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (out_valid) out_cnt++;
    end
    chk("abort.noOV", 32'(out_cnt), 32'd0);

    // Post-reset sample: delay line cleared, coefficients reloaded
    s_valid = 1'b1; s_data = 18'd8;
    step(); s_valid = 1'b0;
    chk_tap("s6t0", 1, 8, 1); step();
    chk_tap("s6t1", 2, 0, 0); step();
    chk_tap("s6t2", 3, 0, 0); step();
    chk_tap("s6t3", 4, 0, 0); step();
    step();
    chk_quiet("s6done", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
